// File: rtl/data_mem_reader_pkg.sv
// Shared types and constants for the data memory readout engine.
package data_mem_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    OUTPUT,
    FINISH
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/data_mem_reader_word_assembler.sv
// 8-to-32 big-endian shift register: the first byte shifted in ends up in bits 31:24.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {word[23:0], byte_in};
    end
  end

endmodule

// File: rtl/data_mem_reader.sv
// Walks a word range of the byte-wide data memory and streams big-endian words out.
module data_mem_reader
  import data_mem_reader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(BYTES_PER_WORD);
  localparam logic [1:0]        LAST_BYTE  = 2'(BYTES_PER_WORD - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] word_addr;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        byte_idx;
  logic              rd_pending;
  logic              asm_clear;

  // The assembler register doubles as out_word; it only moves while bytes are returning.
  word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (asm_clear),
    .shift_en (rd_pending),
    .byte_in  (rd_data),
    .word     (out_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rd_pending marks the cycle in which rd_data carries a requested byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_addr  <= '0;
      remaining  <= '0;
      byte_idx   <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            word_addr <= base_addr & ALIGN_MASK;
            remaining <= word_count;
            byte_idx  <= '0;
          end
        end
        READ: begin
          byte_idx <= byte_idx + 2'd1;
        end
        OUTPUT: begin
          if (out_ready) begin
            remaining <= remaining - CNT_W'(1);
            word_addr <= word_addr + WORD_STEP;
            byte_idx  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    asm_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          asm_clear  = 1'b1;
          state_next = (word_count == '0) ? FINISH : READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = word_addr + ADDR_W'(byte_idx);
        if (byte_idx == LAST_BYTE) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = OUTPUT;
      end
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = (remaining == CNT_W'(1)) ? FINISH : READ;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_reader.sv
// Directed bench for data_mem_reader with a 1-cycle byte memory model and per-cycle trace.
module tb_data_mem_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  logic [7:0] mem [0:255];

  int cyc;
  int start_cyc;
  int session;
  int seen_session;
  int rel;

  logic        h_rd_en   [0:63];
  logic        h_valid   [0:63];
  logic        h_done    [0:63];
  logic        h_busy    [0:63];
  logic [31:0] h_word    [0:63];
  logic [31:0] h_rd_addr [0:63];
  logic [31:0] rd_log [$];
  logic [31:0] word_log [$];
  int          done_cnt;

  data_mem_reader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bytes come back one cycle after the strobe; otherwise the bus carries junk.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[7:0]] : 8'hA5;

  // Trace indexed by cycle number after the start edge (cycle 1 follows the edge).
  always @(negedge clk) begin
    if (session != seen_session) begin
      seen_session = session;
      rd_log.delete();
      word_log.delete();
      done_cnt = 0;
      for (int k = 0; k < 64; k++) begin
        h_rd_en[k] = 1'b0; h_valid[k] = 1'b0; h_done[k] = 1'b0;
        h_busy[k] = 1'b0; h_word[k] = '0; h_rd_addr[k] = '0;
      end
    end
    if (session > 0) begin
      rel = cyc - start_cyc + 1;
      if (rel >= 1 && rel < 64) begin
        h_rd_en[rel] = rd_en; h_valid[rel] = out_valid; h_done[rel] = done;
        h_busy[rel] = busy; h_word[rel] = out_word; h_rd_addr[rel] = rd_addr;
      end
      if (rd_en) rd_log.push_back(rd_addr);
      if (out_valid && out_ready) word_log.push_back(out_word);
      if (done) done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; returns in cycle 1 after the accepting edge.
  task automatic apply_start(input logic [31:0] b, input logic [15:0] c);
    step(1);
    base_addr = b; word_count = c; start = 1'b1;
    step(1);
    start = 1'b0;
    start_cyc = cyc;
    session++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    @(negedge clk);
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en: got %b, expected 0", rd_en); end
    vectors++; if (rd_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rd_addr: got %h, expected 0", rd_addr); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    vectors++; if (out_word !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_word: got %h, expected 0", out_word); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_two_words();
    int fv;
    int nrd;
    out_ready = 1'b1;
    apply_start(32'h0, 16'd2);
    step(20);
    fv = -1; nrd = 0;
    for (int k = 1; k < 64; k++) if (h_valid[k] && fv < 0) fv = k;
    for (int k = 1; k <= 4; k++) if (h_rd_en[k]) nrd++;
    vectors++; if (h_busy[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL two_busy_c1: got %b, expected 1", h_busy[1]); end
    vectors++; if (nrd != 4 || h_rd_en[5] !== 1'b0) begin miscompares++; $display("[TB] FAIL two_rd_en_window: got %0d strobes c1-4 and %b at c5, expected 4 and 0", nrd, h_rd_en[5]); end
    vectors++; if (fv != 6) begin miscompares++; $display("[TB] FAIL two_first_valid: got cycle %0d, expected 6", fv); end
    vectors++; if (rd_log.size() != 8) begin miscompares++; $display("[TB] FAIL two_rd_count: got %0d, expected 8", rd_log.size()); end
    for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
      vectors++; if (rd_log[i] !== 32'(i)) begin miscompares++; $display("[TB] FAIL two_rd_addr[%0d]: got %h, expected %h", i, rd_log[i], i); end
    end
    vectors++; if (word_log.size() != 2) begin miscompares++; $display("[TB] FAIL two_word_count: got %0d, expected 2", word_log.size()); end
    vectors++; if (word_log[0] !== 32'h00000000) begin miscompares++; $display("[TB] FAIL two_word0: got %h, expected 00000000", word_log[0]); end
    vectors++; if (word_log[1] !== 32'h00000028) begin miscompares++; $display("[TB] FAIL two_word1: got %h, expected 00000028", word_log[1]); end
    vectors++; if (done_cnt != 1 || h_done[13] !== 1'b1) begin miscompares++; $display("[TB] FAIL two_done: got %0d pulses, c13=%b, expected 1 pulse at c13", done_cnt, h_done[13]); end
    vectors++; if (h_busy[13] !== 1'b0) begin miscompares++; $display("[TB] FAIL two_busy_at_done: got %b, expected 0", h_busy[13]); end
  endtask

  task automatic test_unaligned();
    int fv;
    out_ready = 1'b1;
    apply_start(32'h0000000B, 16'd1);
    step(12);
    fv = -1;
    for (int k = 1; k < 64; k++) if (h_valid[k] && fv < 0) fv = k;
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("[TB] FAIL unal_rd_count: got %0d, expected 4", rd_log.size()); end
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      vectors++; if (rd_log[i] !== 32'(8 + i)) begin miscompares++; $display("[TB] FAIL unal_rd_addr[%0d]: got %h, expected %h", i, rd_log[i], 8 + i); end
    end
    vectors++; if (word_log[0] !== 32'h12345678 || word_log.size() != 1) begin miscompares++; $display("[TB] FAIL unal_word: got %h (n=%0d), expected 12345678 (n=1)", word_log[0], word_log.size()); end
    vectors++; if (fv != 6) begin miscompares++; $display("[TB] FAIL unal_first_valid: got cycle %0d, expected 6", fv); end
    vectors++; if (h_done[7] !== 1'b1) begin miscompares++; $display("[TB] FAIL unal_done_c7: got %b, expected 1", h_done[7]); end
  endtask

  task automatic test_stall();
    int nstable;
    int nrd;
    out_ready = 1'b0;
    apply_start(32'h00000020, 16'd2);
    step(15);
    out_ready = 1'b1;
    step(12);
    nstable = 0; nrd = 0;
    for (int k = 6; k <= 16; k++) if (h_valid[k] === 1'b1 && h_word[k] === 32'hA1B2C3D4) nstable++;
    for (int k = 5; k <= 16; k++) if (h_rd_en[k]) nrd++;
    vectors++; if (nstable != 11) begin miscompares++; $display("[TB] FAIL stall_hold: got %0d stable cycles, expected 11", nstable); end
    vectors++; if (nrd != 0) begin miscompares++; $display("[TB] FAIL stall_no_read: got %0d strobes, expected 0", nrd); end
    vectors++; if (h_rd_en[17] !== 1'b1 || h_rd_addr[17] !== 32'h24) begin miscompares++; $display("[TB] FAIL stall_resume: got rd_en=%b addr=%h at c17, expected 1 and 24", h_rd_en[17], h_rd_addr[17]); end
    vectors++; if (word_log.size() != 2 || word_log[0] !== 32'hA1B2C3D4 || word_log[1] !== 32'h11223344) begin miscompares++; $display("[TB] FAIL stall_words: got n=%0d %h %h, expected A1B2C3D4 11223344", word_log.size(), word_log[0], word_log[1]); end
    vectors++; if (done_cnt != 1 || h_done[23] !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_done: got %0d pulses c23=%b, expected 1 at c23", done_cnt, h_done[23]); end
  endtask

  task automatic test_zero_count();
    int nvalid;
    out_ready = 1'b1;
    apply_start(32'h00000040, 16'd0);
    step(6);
    nvalid = 0;
    for (int k = 1; k <= 6; k++) if (h_valid[k]) nvalid++;
    vectors++; if (h_done[1] !== 1'b1 || done_cnt != 1) begin miscompares++; $display("[TB] FAIL zero_done: got c1=%b n=%0d, expected 1 and 1", h_done[1], done_cnt); end
    vectors++; if (rd_log.size() != 0) begin miscompares++; $display("[TB] FAIL zero_no_read: got %0d strobes, expected 0", rd_log.size()); end
    vectors++; if (nvalid != 0) begin miscompares++; $display("[TB] FAIL zero_no_valid: got %0d, expected 0", nvalid); end
    vectors++; if (h_busy[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy: got %b, expected 0", h_busy[1]); end
  endtask

  task automatic test_start_while_busy();
    int nrd;
    out_ready = 1'b1;
    apply_start(32'h00000008, 16'd1);
    step(1);
    base_addr = 32'h20; word_count = 16'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    base_addr = 32'h20; word_count = 16'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    nrd = 0;
    for (int k = 8; k <= 20; k++) if (h_rd_en[k]) nrd++;
    vectors++; if (rd_log.size() != 4) begin miscompares++; $display("[TB] FAIL busy_rd_count: got %0d, expected 4", rd_log.size()); end
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      vectors++; if (rd_log[i] !== 32'(8 + i)) begin miscompares++; $display("[TB] FAIL busy_rd_addr[%0d]: got %h, expected %h", i, rd_log[i], 8 + i); end
    end
    vectors++; if (word_log.size() != 1 || word_log[0] !== 32'h12345678) begin miscompares++; $display("[TB] FAIL busy_word: got n=%0d %h, expected 12345678", word_log.size(), word_log[0]); end
    vectors++; if (done_cnt != 1 || nrd != 0) begin miscompares++; $display("[TB] FAIL busy_done_start_ignored: got %0d pulses %0d late strobes, expected 1 and 0", done_cnt, nrd); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    apply_start(32'h00000008, 16'd1);
    step(6);
    base_addr = 32'h20; word_count = 16'd1; start = 1'b1;
    step(2);
    start = 1'b0;
    step(10);
    vectors++; if (h_done[7] !== 1'b1 || h_rd_en[8] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ignore_at_done: got done=%b rd_en_c8=%b, expected 1 and 0", h_done[7], h_rd_en[8]); end
    vectors++; if (h_rd_en[9] !== 1'b1 || h_rd_addr[9] !== 32'h20) begin miscompares++; $display("[TB] FAIL b2b_accept_idle: got rd_en=%b addr=%h at c9, expected 1 and 20", h_rd_en[9], h_rd_addr[9]); end
    vectors++; if (word_log.size() != 2 || word_log[1] !== 32'hA1B2C3D4) begin miscompares++; $display("[TB] FAIL b2b_word: got n=%0d %h, expected A1B2C3D4", word_log.size(), word_log[1]); end
    vectors++; if (done_cnt != 2 || h_done[15] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done: got %0d pulses c15=%b, expected 2 and 1", done_cnt, h_done[15]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    apply_start(32'h00000030, 16'd3);
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(25);
    vectors++; if (h_rd_en[6] !== 1'b0 || h_rd_addr[6] !== 32'h0) begin miscompares++; $display("[TB] FAIL rmid_rd: got rd_en=%b addr=%h, expected 0 and 0", h_rd_en[6], h_rd_addr[6]); end
    vectors++; if (h_valid[6] !== 1'b0 || h_word[6] !== 32'h0) begin miscompares++; $display("[TB] FAIL rmid_out: got valid=%b word=%h, expected 0 and 0", h_valid[6], h_word[6]); end
    vectors++; if (h_busy[6] !== 1'b0 || h_done[6] !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_status: got busy=%b done=%b, expected 0 0", h_busy[6], h_done[6]); end
    vectors++; if (done_cnt != 0 || word_log.size() != 0 || rd_log.size() != 4) begin miscompares++; $display("[TB] FAIL rmid_abort: got done=%0d words=%0d reads=%0d, expected 0 0 4", done_cnt, word_log.size(), rd_log.size()); end
    apply_start(32'h00000008, 16'd1);
    step(10);
    vectors++; if (rd_log.size() != 4 || rd_log[0] !== 32'h8) begin miscompares++; $display("[TB] FAIL rmid_restart_addr: got n=%0d first=%h, expected 4 and 8", rd_log.size(), rd_log[0]); end
    vectors++; if (word_log.size() != 1 || word_log[0] !== 32'h12345678 || done_cnt != 1) begin miscompares++; $display("[TB] FAIL rmid_restart_word: got n=%0d %h done=%0d, expected 12345678 and 1", word_log.size(), word_log[0], done_cnt); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    cyc = 0; start_cyc = 0; session = 0; seen_session = 0; rel = 0; done_cnt = 0;
    start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1; reset = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    mem[7] = 8'd40;
    mem[8] = 8'h12; mem[9] = 8'h34; mem[10] = 8'h56; mem[11] = 8'h78;
    mem[32] = 8'hA1; mem[33] = 8'hB2; mem[34] = 8'hC3; mem[35] = 8'hD4;
    mem[36] = 8'h11; mem[37] = 8'h22; mem[38] = 8'h33; mem[39] = 8'h44;
    for (int k = 0; k < 12; k++) mem[48 + k] = 8'(k + 1);

    test_reset();
    test_two_words();
    test_unaligned();
    test_stall();
    test_zero_count();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
